e_stage_reg: RTL and testbench

- D→E pipeline register of the P8 five-stage MIPS pipeline.
- Consumes the hazard controller's stall/flush decisions: it inserts bubbles, holds, or flushes the E stage.
- Publishes tnew_e/writereg_e back to the hazard controller.
- Owns the multiply/divide busy counter that backs the controller's MD-class (tnew==5) stall.

---
 rtl/e_stage_reg.sv | 119 +++++++++++
 tb/tb_e_stage_reg.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/e_stage_reg.sv
// D->E pipeline register: applies flush/stall/bubble control from the hazard
// controller and runs the multiply/divide busy counter behind the MD-class stall.
module e_stage_reg #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_d,
  input  logic [31:0] instr_d,
  input  logic [31:0] rs_val_d,
  input  logic [31:0] rt_val_d,
  input  logic [31:0] ext_imm_d,
  input  logic [4:0]  writereg_d,
  input  logic [3:0]  tnew_d,
  input  logic [1:0]  md_start_d,
  input  logic        bd_d,
  input  logic        bubble_e,
  input  logic        stall_e,
  input  logic        flush_e,
  output logic [31:0] pc_e,
  output logic [31:0] instr_e,
  output logic [31:0] rs_val_e,
  output logic [31:0] rt_val_e,
  output logic [31:0] ext_imm_e,
  output logic [4:0]  writereg_e,
  output logic [3:0]  tnew_e,
  output logic        bd_e,
  output logic        valid_e,
  output logic        md_busy
);

  localparam int unsigned CNT_W = 4;
  localparam logic [1:0]  MD_NONE = 2'b00;
  localparam logic [1:0]  MD_MULT = 2'b01;
  localparam logic [1:0]  MD_DIV  = 2'b10;

  logic [1:0]       md_kind_e;
  logic [CNT_W-1:0] md_cnt;
  logic [CNT_W-1:0] md_cnt_nxt;
  logic             md_go;

  // E-stage contents; priority flush > stall > bubble > load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_e       <= '0;
      instr_e    <= '0;
      rs_val_e   <= '0;
      rt_val_e   <= '0;
      ext_imm_e  <= '0;
      writereg_e <= '0;
      tnew_e     <= '0;
      bd_e       <= 1'b0;
      valid_e    <= 1'b0;
      md_kind_e  <= MD_NONE;
    end else if (flush_e) begin
      pc_e       <= '0;
      instr_e    <= '0;
      rs_val_e   <= '0;
      rt_val_e   <= '0;
      ext_imm_e  <= '0;
      writereg_e <= '0;
      tnew_e     <= '0;
      bd_e       <= 1'b0;
      valid_e    <= 1'b0;
      md_kind_e  <= MD_NONE;
    end else if (stall_e) begin
      pc_e       <= pc_e;
    end else if (bubble_e) begin
      // bubble keeps the stalled instruction's PC/BD so EPC stays correct
      pc_e       <= pc_d;
      bd_e       <= bd_d;
      instr_e    <= '0;
      rs_val_e   <= '0;
      rt_val_e   <= '0;
      ext_imm_e  <= '0;
      writereg_e <= '0;
      tnew_e     <= '0;
      valid_e    <= 1'b0;
      md_kind_e  <= MD_NONE;
    end else begin
      pc_e       <= pc_d;
      instr_e    <= instr_d;
      rs_val_e   <= rs_val_d;
      rt_val_e   <= rt_val_d;
      ext_imm_e  <= ext_imm_d;
      writereg_e <= writereg_d;
      tnew_e     <= tnew_d;
      bd_e       <= bd_d;
      valid_e    <= 1'b1;
      md_kind_e  <= (md_start_d == 2'b11) ? MD_NONE : md_start_d;
    end
  end

  // Counter starts only when a latched mult/div actually leaves E
  always_comb begin
    md_go      = (md_kind_e != MD_NONE) && !flush_e && !stall_e;
    md_cnt_nxt = md_cnt;
    if (md_go) begin
      md_cnt_nxt = (md_kind_e == MD_MULT) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
    end else if (md_cnt != '0) begin
      md_cnt_nxt = md_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt  <= '0;
      md_busy <= 1'b0;
    end else begin
      md_cnt  <= md_cnt_nxt;
      md_busy <= (md_cnt_nxt != '0);
    end
  end

  logic unused_div_code;
  assign unused_div_code = (MD_DIV == 2'b10);

endmodule

// File: tb/tb_e_stage_reg.sv
// Randomized scoreboard bench for e_stage_reg with a cycle-indexed reference model.
module tb_e_stage_reg;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  typedef struct {
    logic [31:0] pc, instr, rs, rt, imm;
    logic [4:0]  wr;
    logic [3:0]  tnew;
    logic [1:0]  md;
    logic        bd, bubble, stall, flush;
  } din_t;

  typedef struct {
    logic [31:0] pc, instr, rs, rt, imm;
    logic [4:0]  wr;
    logic [3:0]  tnew;
    logic        bd, valid, busy;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_d, instr_d, rs_val_d, rt_val_d, ext_imm_d;
  logic [4:0]  writereg_d;
  logic [3:0]  tnew_d;
  logic [1:0]  md_start_d;
  logic        bd_d, bubble_e, stall_e, flush_e;
  logic [31:0] pc_e, instr_e, rs_val_e, rt_val_e, ext_imm_e;
  logic [4:0]  writereg_e;
  logic [3:0]  tnew_e;
  logic        bd_e, valid_e, md_busy;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // model state: E contents, kind of MD op held in E, and edge index until which md_busy holds
  exp_t m;
  int   md_kind;
  int   edge_n;
  int   busy_until;

  e_stage_reg #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset),
    .pc_d(pc_d), .instr_d(instr_d), .rs_val_d(rs_val_d), .rt_val_d(rt_val_d),
    .ext_imm_d(ext_imm_d), .writereg_d(writereg_d), .tnew_d(tnew_d),
    .md_start_d(md_start_d), .bd_d(bd_d), .bubble_e(bubble_e), .stall_e(stall_e),
    .flush_e(flush_e),
    .pc_e(pc_e), .instr_e(instr_e), .rs_val_e(rs_val_e), .rt_val_e(rt_val_e),
    .ext_imm_e(ext_imm_e), .writereg_e(writereg_e), .tnew_e(tnew_e), .bd_e(bd_e),
    .valid_e(valid_e), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic exp_t zero_exp();
    exp_t z;
    z.pc = '0; z.instr = '0; z.rs = '0; z.rt = '0; z.imm = '0;
    z.wr = '0; z.tnew = '0; z.bd = 1'b0; z.valid = 1'b0; z.busy = 1'b0;
    return z;
  endfunction

  function automatic din_t nop();
    din_t d;
    d.pc = '0; d.instr = '0; d.rs = '0; d.rt = '0; d.imm = '0; d.wr = '0;
    d.tnew = '0; d.md = '0; d.bd = 1'b0; d.bubble = 1'b0; d.stall = 1'b0; d.flush = 1'b0;
    return d;
  endfunction

  function automatic din_t rand_din();
    din_t d;
    d.pc = $urandom; d.instr = $urandom; d.rs = $urandom; d.rt = $urandom; d.imm = $urandom;
    d.wr = 5'($urandom); d.tnew = 4'($urandom_range(0, 5)); d.md = 2'($urandom);
    d.bd = 1'($urandom);
    d.flush  = ($urandom_range(0, 9) == 0);
    d.stall  = ($urandom_range(0, 5) == 0);
    d.bubble = ($urandom_range(0, 5) == 0);
    return d;
  endfunction

  task automatic compare_all(input string tag, input exp_t e);
    check({tag, ".pc_e"},       pc_e,                e.pc);
    check({tag, ".instr_e"},    instr_e,             e.instr);
    check({tag, ".rs_val_e"},   rs_val_e,            e.rs);
    check({tag, ".rt_val_e"},   rt_val_e,            e.rt);
    check({tag, ".ext_imm_e"},  ext_imm_e,           e.imm);
    check({tag, ".writereg_e"}, 32'(writereg_e),     32'(e.wr));
    check({tag, ".tnew_e"},     32'(tnew_e),         32'(e.tnew));
    check({tag, ".bd_e"},       32'(bd_e),           32'(e.bd));
    check({tag, ".valid_e"},    32'(valid_e),        32'(e.valid));
    check({tag, ".md_busy"},    32'(md_busy),        32'(e.busy));
  endtask

  // one clock: drive D inputs at negedge, advance the model, queue the expected E state
  task automatic cycle(input din_t d);
    @(negedge clk);
    pc_d = d.pc; instr_d = d.instr; rs_val_d = d.rs; rt_val_d = d.rt; ext_imm_d = d.imm;
    writereg_d = d.wr; tnew_d = d.tnew; md_start_d = d.md; bd_d = d.bd;
    bubble_e = d.bubble; stall_e = d.stall; flush_e = d.flush;
    edge_n++;
    if (reset) begin
      m = zero_exp(); md_kind = 0; busy_until = 0;
    end else begin
      if (md_kind != 0 && !d.flush && !d.stall)
        busy_until = edge_n + ((md_kind == 1) ? int'(MULT_N) : int'(DIV_N));
      if (d.flush) begin
        m = zero_exp(); md_kind = 0;
      end else if (d.stall) begin
        md_kind = md_kind;
      end else if (d.bubble) begin
        m = zero_exp(); m.pc = d.pc; m.bd = d.bd; md_kind = 0;
      end else begin
        m.pc = d.pc; m.instr = d.instr; m.rs = d.rs; m.rt = d.rt; m.imm = d.imm;
        m.wr = d.wr; m.tnew = d.tnew; m.bd = d.bd; m.valid = 1'b1;
        md_kind = (d.md == 2'b11) ? 0 : int'(d.md);
      end
    end
    m.busy = (edge_n < busy_until);
    exp_q.push_back(m);
  endtask

  task automatic peek();
    @(posedge clk);
    #2;
  endtask

  task automatic count_busy(input int n_cycles, input int stall_at, output int n_high);
    din_t d;
    n_high = 0;
    for (int i = 0; i < n_cycles; i++) begin
      d = nop();
      d.stall = (i == stall_at);
      cycle(d);
      peek();
      if (md_busy) n_high++;
    end
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3 reset = 1'b1;
    #1 compare_all("async_reset", zero_exp());
    cycle(nop());
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  // monitor: every edge after the first queued transaction, compare the DUT to the model
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare_all("sb", e);
      end
    end
  end

  initial begin
    din_t d;
    int   n;
    reset = 1'b1;
    m = zero_exp(); md_kind = 0; edge_n = 0; busy_until = 0;
    d = nop();
    pc_d = '0; instr_d = '0; rs_val_d = '0; rt_val_d = '0; ext_imm_d = '0;
    writereg_d = '0; tnew_d = '0; md_start_d = '0; bd_d = 1'b0;
    bubble_e = 1'b0; stall_e = 1'b0; flush_e = 1'b0;
    repeat (2) @(posedge clk);
    #1 compare_all("reset", zero_exp());
    #1 reset = 1'b0;

    // load then bubble
    d = nop(); d.pc = 32'h3000; d.instr = 32'h012A4020; d.wr = 5'd8; d.tnew = 4'd1;
    cycle(d); peek();
    check("load.instr", instr_e, 32'h012A4020);
    check("load.wr", 32'(writereg_e), 32'd8);
    check("load.valid", 32'(valid_e), 32'd1);
    d = nop(); d.pc = 32'h3004; d.bd = 1'b1; d.bubble = 1'b1; d.instr = 32'hDEAD0000; d.wr = 5'd9;
    cycle(d); peek();
    check("bubble.pc", pc_e, 32'h3004);
    check("bubble.bd", 32'(bd_e), 32'd1);
    check("bubble.instr", instr_e, 32'h0);
    check("bubble.valid", 32'(valid_e), 32'd0);

    // simultaneous controls
    d = nop(); d.pc = 32'h3008; d.instr = 32'h11111111; d.wr = 5'd3;
    cycle(d);
    d = nop(); d.pc = 32'h4000; d.stall = 1'b1; d.bubble = 1'b1;
    cycle(d); peek();
    check("stall_bubble.pc", pc_e, 32'h3008);
    check("stall_bubble.instr", instr_e, 32'h11111111);
    d = nop(); d.pc = 32'h5000; d.stall = 1'b1; d.flush = 1'b1;
    cycle(d); peek();
    check("flush_stall.pc", pc_e, 32'h0);
    check("flush_stall.valid", 32'(valid_e), 32'd0);

    // mult timing
    d = nop(); d.md = 2'b01; d.tnew = 4'd5; d.pc = 32'h3010;
    cycle(d); peek();
    check("mult.tnew", 32'(tnew_e), 32'd5);
    check("mult.busy_in_e", 32'(md_busy), 32'd0);
    count_busy(8, -1, n);
    check("mult.busy_cycles", 32'(n), 32'(MULT_N));

    // div held under stall, then counted with a stall inside the count
    d = nop(); d.md = 2'b10; d.tnew = 4'd5;
    cycle(d);
    for (int i = 0; i < 3; i++) begin
      d = nop(); d.stall = 1'b1;
      cycle(d); peek();
      check("div_stall.busy", 32'(md_busy), 32'd0);
    end
    count_busy(13, 3, n);
    check("div.busy_cycles", 32'(n), 32'(DIV_N));

    // flushed MD and md_start 11
    d = nop(); d.md = 2'b10;
    cycle(d);
    d = nop(); d.flush = 1'b1;
    cycle(d); peek();
    check("md_flush.valid", 32'(valid_e), 32'd0);
    count_busy(3, -1, n);
    check("md_flush.busy_cycles", 32'(n), 32'd0);
    d = nop(); d.md = 2'b11;
    cycle(d);
    count_busy(3, -1, n);
    check("md_11.busy_cycles", 32'(n), 32'd0);

    // reset mid-run, then first load valid
    for (int i = 0; i < 6; i++) cycle(rand_din());
    async_reset();
    d = nop(); d.pc = 32'h3100;
    cycle(d); peek();
    check("post_reset.valid", 32'(valid_e), 32'd1);

    for (int i = 0; i < 400; i++) cycle(rand_din());
    for (int i = 0; i < 4; i++) cycle(rand_din());
    async_reset();
    for (int i = 0; i < 200; i++) cycle(rand_din());

    repeat (2) @(posedge clk);
    #3;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
